// File: rtl/router_out_sched.sv
// Per-output-port NoC scheduler: round-robin pick among input buffers, then send the 32-bit packet as 4 bytes.
// Optional WAIT_FREE watchdog is built when ROUTER_SCHED_WDOG_EN is defined.
module router_out_sched #(
    parameter int NUM_IN  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_IN-1:0]      req,
    input  logic [NUM_IN-1:0][31:0] pkt_in,
    output logic [NUM_IN-1:0]      grant,
    input  logic                   free_outbound,
    output logic                   put_outbound,
    output logic [7:0]             payload_outbound,
    output logic                   busy,
    output logic                   wdog_err
);
    localparam int PW = $clog2(NUM_IN);

    typedef enum logic [1:0] {IDLE, WAIT_FREE, SEND} state_t;

    state_t        state, state_next;
    logic [PW-1:0] ptr;
    logic [PW-1:0] winner;
    logic [PW:0]   probe;
    logic          found;
    logic          load;
    logic [1:0]    cnt;
    logic [31:0]   pkt_sr;

    // First requester at or after ptr, wrapping modulo NUM_IN.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        probe  = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            probe = {1'b0, ptr} + (PW+1)'(k);
            if (probe >= (PW+1)'(NUM_IN))
                probe = probe - (PW+1)'(NUM_IN);
            if (!found && req[probe[PW-1:0]]) begin
                winner = probe[PW-1:0];
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = WAIT_FREE;
                    load       = 1'b1;
                end
            end
            WAIT_FREE: begin
                if (free_outbound)
                    state_next = SEND;
            end
            SEND: begin
                if (cnt == 2'd3)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            grant <= '0;
            cnt   <= 2'd0;
        end else begin
            state <= state_next;
            grant <= '0;
            cnt   <= (state == SEND) ? cnt + 2'd1 : 2'd0;
            if (load) begin
                grant <= NUM_IN'(1) << winner;
                ptr   <= (winner == PW'(NUM_IN-1)) ? '0 : winner + PW'(1);
            end
        end
    end

    // Packet register carries data only; the state decides whether it is visible.
    always_ff @(posedge clk) begin
        if (load)
            pkt_sr <= pkt_in[winner];
        else if (state == SEND)
            pkt_sr <= {pkt_sr[23:0], 8'h00};
    end

    // Outputs decode straight from state so an asynchronous reset silences the link at once.
    assign busy             = (state != IDLE);
    assign put_outbound     = (state == SEND);
    assign payload_outbound = (state == SEND) ? pkt_sr[31:24] : 8'h00;

`ifdef ROUTER_SCHED_WDOG_EN
    localparam int WW = ($clog2(TIMEOUT+1) > 8) ? $clog2(TIMEOUT+1) : 8;

    logic [WW-1:0] wcnt;
    logic          err;

    // Counter saturates at TIMEOUT; the error flag is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= '0;
            err  <= 1'b0;
        end else if (state == WAIT_FREE) begin
            if (wcnt != WW'(TIMEOUT))
                wcnt <= wcnt + WW'(1);
            if (wcnt == WW'(TIMEOUT-1))
                err <= 1'b1;
        end else begin
            wcnt <= '0;
        end
    end

    assign wdog_err = err;
`else
    assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_out_sched.sv
// Scoreboard bench for router_out_sched: expected grants/bytes queued at stimulus time, popped as the DUT emits them.
module tb_router_out_sched;
    logic             clk;
    logic             rst;
    logic [3:0]       req;
    logic [3:0][31:0] pkt_in;
    logic [3:0]       grant;
    logic             free_outbound;
    logic             put_outbound;
    logic [7:0]       payload_outbound;
    logic             busy;
    logic             wdog_err;

    int         vec;
    int         errs;
    logic [7:0] exp_b[$];
    int         exp_g[$];

    router_out_sched #(.NUM_IN(4), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .req(req), .pkt_in(pkt_in), .grant(grant),
        .free_outbound(free_outbound), .put_outbound(put_outbound),
        .payload_outbound(payload_outbound), .busy(busy), .wdog_err(wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pv(input int i, input int k);
        return 32'(32'h1020_3040 + i * 32'h0111_1111 + k * 32'h0800_0080);
    endfunction

    task automatic push_pkt(input logic [31:0] p);
        for (int j = 3; j >= 0; j--) exp_b.push_back(p[j*8 +: 8]);
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; free_outbound = 1'b0;
        for (int i = 0; i < 4; i++) pkt_in[i] = '0;
        @(negedge clk);
        vec++;
        if ({grant, put_outbound, payload_outbound, busy, wdog_err} !== 15'h0) begin
            errs++;
            $display("FAIL reset_state: grant=%b put=%b payload=%h busy=%b wdog=%b, required all 0",
                     grant, put_outbound, payload_outbound, busy, wdog_err);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] e;
        @(negedge clk);
        req = 4'b0010; pkt_in[1] = 32'h12AB_CDEF; free_outbound = 1'b1;
        push_pkt(32'h12AB_CDEF);
        @(negedge clk);
        vec++;
        if (grant !== 4'b0010 || put_outbound !== 1'b0 || busy !== 1'b1) begin
            errs++;
            $display("FAIL single_grant: grant=%b put=%b busy=%b, required 0010/0/1", grant, put_outbound, busy);
        end
        req = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            e = exp_b.pop_front();
            vec++;
            if (put_outbound !== 1'b1 || payload_outbound !== e || grant !== 4'b0000) begin
                errs++;
                $display("FAIL single_byte%0d: put=%b payload=%h grant=%b, required 1/%h/0000",
                         c, put_outbound, payload_outbound, grant, e);
            end
        end
        @(negedge clk);
        vec++;
        if (put_outbound !== 1'b0 || busy !== 1'b0 || payload_outbound !== 8'h00) begin
            errs++;
            $display("FAIL single_done: put=%b busy=%b payload=%h, required 0/0/00", put_outbound, busy, payload_outbound);
        end
    endtask

    task automatic test_round_robin();
        int ng;
        int last;
        int g;
        logic [7:0] e;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) pkt_in[i] = pv(i, 0);
        req = 4'b1111; free_outbound = 1'b1;
        exp_g = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) push_pkt(pv(i, 0));
        push_pkt(pv(0, 1));
        ng = 0; last = -1;
        for (int cyc = 0; cyc < 80 && (exp_g.size() != 0 || exp_b.size() != 0); cyc++) begin
            @(negedge clk);
            if (grant !== 4'b0000) begin
                g = (exp_g.size() != 0) ? exp_g.pop_front() : 0;
                vec++;
                if (grant !== 4'(1 << g)) begin
                    errs++;
                    $display("FAIL rr_grant%0d: grant=%b, required %b", ng, grant, 4'(1 << g));
                end
                if (last >= 0) begin
                    vec++;
                    if (cyc - last !== 6) begin
                        errs++;
                        $display("FAIL rr_spacing%0d: %0d cycles, required 6", ng, cyc - last);
                    end
                end
                last = cyc;
                pkt_in[g] = pv(g, 1);
                ng++;
                if (ng == 5) req = '0;
            end
            if (put_outbound === 1'b1) begin
                e = (exp_b.size() != 0) ? exp_b.pop_front() : 8'hxx;
                vec++;
                if (payload_outbound !== e) begin
                    errs++;
                    $display("FAIL rr_byte: payload=%h, required %h", payload_outbound, e);
                end
            end
        end
        vec++;
        if (exp_g.size() != 0 || exp_b.size() != 0) begin
            errs++;
            $display("FAIL rr_timeout: %0d grants and %0d bytes outstanding, required 0/0", exp_g.size(), exp_b.size());
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_wait_free();
        int bad;
        logic [7:0] e;
        @(negedge clk);
        req = 4'b0001; pkt_in[0] = 32'hA1B2_C3D4; free_outbound = 1'b0;
        push_pkt(32'hA1B2_C3D4);
        @(negedge clk);
        vec++;
        if (grant !== 4'b0001) begin
            errs++;
            $display("FAIL wait_grant: grant=%b, required 0001", grant);
        end
        req = '0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (put_outbound !== 1'b0 || busy !== 1'b1 || grant !== 4'b0000) bad++;
        end
        vec++;
        if (bad != 0) begin
            errs++;
            $display("FAIL wait_hold: %0d cycles with put/busy/grant wrong, required 0", bad);
        end
        free_outbound = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            e = exp_b.pop_front();
            vec++;
            if (put_outbound !== 1'b1 || payload_outbound !== e) begin
                errs++;
                $display("FAIL wait_byte%0d: put=%b payload=%h, required 1/%h", c, put_outbound, payload_outbound, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_free_drop();
        logic [7:0] e;
        @(negedge clk);
        req = 4'b0100; pkt_in[2] = 32'h5566_7788; free_outbound = 1'b1;
        push_pkt(32'h5566_7788);
        @(negedge clk);
        req = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            e = exp_b.pop_front();
            vec++;
            if (put_outbound !== 1'b1 || payload_outbound !== e) begin
                errs++;
                $display("FAIL drop_byte%0d: put=%b payload=%h, required 1/%h", c, put_outbound, payload_outbound, e);
            end
            if (c == 1) free_outbound = 1'b0;
        end
        @(negedge clk);
        vec++;
        if (put_outbound !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL drop_done: put=%b busy=%b, required 0/0", put_outbound, busy);
        end
        free_outbound = 1'b1;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req = 4'b0001; pkt_in[0] = 32'hDEAD_BEEF; pkt_in[1] = 32'h0BAD_F00D;
        @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);
        vec++;
        if (put_outbound !== 1'b1 || payload_outbound !== 8'hBE) begin
            errs++;
            $display("FAIL mid_pre: put=%b payload=%h, required 1/be", put_outbound, payload_outbound);
        end
        rst = 1'b1;
        #1;
        vec++;
        if (put_outbound !== 1'b0 || payload_outbound !== 8'h00 || busy !== 1'b0) begin
            errs++;
            $display("FAIL mid_async: put=%b payload=%h busy=%b, required 0/00/0", put_outbound, payload_outbound, busy);
        end
        @(negedge clk);
        rst = 1'b0; req = 4'b0011;
        @(negedge clk);
        vec++;
        if (grant !== 4'b0001 || put_outbound !== 1'b0) begin
            errs++;
            $display("FAIL mid_ptr: grant=%b put=%b, required 0001/0", grant, put_outbound);
        end
        req = '0;
        repeat (6) @(negedge clk);
        req = 4'b0100;
        @(negedge clk);
        vec++;
        if (grant !== 4'b0100) begin
            errs++;
            $display("FAIL mid_regrant: grant=%b, required 0100", grant);
        end
        req = '0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_wdog();
        int n;
        @(negedge clk);
        req = 4'b0001; pkt_in[0] = 32'h1357_9BDF; free_outbound = 1'b0;
        @(negedge clk);
        req = '0;
        n = 0;
`ifdef ROUTER_SCHED_WDOG_EN
        while (n < 300 && wdog_err !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        vec++;
        if (n != 255) begin
            errs++;
            $display("FAIL wdog_rise: rose after %0d WAIT_FREE cycles, required 255", n);
        end
`else
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (wdog_err !== 1'b0) n++;
        end
        vec++;
        if (n != 0) begin
            errs++;
            $display("FAIL wdog_off: wdog_err high on %0d cycles, required 0", n);
        end
`endif
        free_outbound = 1'b1;
        repeat (6) @(negedge clk);
        vec++;
`ifdef ROUTER_SCHED_WDOG_EN
        if (wdog_err !== 1'b1 || busy !== 1'b0) begin
            errs++;
            $display("FAIL wdog_sticky: wdog=%b busy=%b, required 1/0", wdog_err, busy);
        end
`else
        if (wdog_err !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL wdog_after: wdog=%b busy=%b, required 0/0", wdog_err, busy);
        end
`endif
    endtask

    initial begin
        vec = 0; errs = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_wait_free();
        test_free_drop();
        test_reset_mid();
        test_wdog();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/router_out_sched.md
Name: router_out_sched

Overview:
- Per-output-port scheduler for the NoC router.
- Arbitrates round-robin among the router's input buffers that hold a packet for this output port.
- Pops the winner's 32-bit packet ({sourceID[3:0], destID[3:0], data[23:0]}) and serializes it as four bytes on the 8-bit free/put/payload link toward a node or the neighbouring router.
- Each router instantiates one per output port (4 per router).

Parameters:
- NUM_IN, 4, number of requesting input buffers (2..8).
- TIMEOUT, 255, cycles in WAIT_FREE before watchdog error (used only with ROUTER_SCHED_WDOG_EN).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- req  input  NUM_IN  req[i]=1: input buffer i holds a head packet destined to this port.
- pkt_in  input  NUM_IN x 32  head packet of each input buffer, valid while req[i]=1.
- grant  output  NUM_IN  one-hot, one-cycle pop pulse to the winning input buffer.
- free_outbound  input  1  downstream can accept one full packet.
- put_outbound  output  1  payload byte valid this cycle.
- payload_outbound  output  8  serialized packet byte.
- busy  output  1  1 in any state other than IDLE.
- wdog_err  output  1  sticky watchdog error (tied 0 without the macro).

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high, rst.
- Reset state: IDLE, ptr=0, grant=0, put_outbound=0, payload_outbound=8'h00, busy=0, wdog_err=0.
- Reset mid-packet aborts immediately. Remaining bytes are dropped; no further put is issued.

States:
- IDLE
  - If req!=0 at an edge, winner i is the first set req index searching ptr, ptr+1, ... with wrap mod NUM_IN.
  - At that edge: latch pkt_in[i] into a 32-bit shift register, set grant[i]=1 for the next cycle only, set ptr=(i+1) mod NUM_IN, go to WAIT_FREE.
  - If req==0, stay in IDLE with outputs 0.
- WAIT_FREE
  - grant returns to 0 after its single cycle.
  - On an edge with free_outbound=1, go to SEND with cnt=0.
  - The next cycle drives put_outbound=1, payload_outbound=pkt[31:24].
- SEND
  - put_outbound=1 for exactly 4 consecutive cycles.
  - Payload order is pkt[31:24], [23:16], [15:8], [7:0]; cnt runs 0..3.
  - After cnt=3, return to IDLE: put_outbound=0, payload_outbound=8'h00.

Latency and handshake:
- Minimum latency from req sampled to first byte is 2 cycles.
- Back-to-back packets have at least 1 IDLE cycle between them, so 6 cycles per packet with free held high.
- req is ignored outside IDLE.
- The requester must dequeue on grant. req[i] seen again in IDLE means the next packet.
- free_outbound is sampled only in WAIT_FREE. Deassertion during SEND does not stall or abort.
- Simultaneous requests resolve by round-robin from ptr.
- A single persistent requester is served every packet.
- No requester is starved: worst-case wait is NUM_IN-1 packets.
- pkt_in is sampled only on the granting edge. Later changes to pkt_in are ignored.

Optional Feature:
- Macro: ROUTER_SCHED_WDOG_EN.
- Defined:
  - An 8+ bit counter increments each cycle in WAIT_FREE and clears on leaving it.
  - When the count reaches TIMEOUT, wdog_err sets to 1 and stays set until rst.
  - The scheduler keeps waiting; the packet is not dropped.
- Undefined:
  - No counter is built.
  - wdog_err is constant 0.

Test Plan:
- Reset, then req=4'b0010, pkt_in[1]=32'h12AB_CDEF, free_outbound=1:
  - grant=4'b0010 for 1 cycle.
  - 2 cycles after the req edge, put=1 for 4 cycles with bytes 12, AB, CD, EF.
  - Then put=0, busy=0.
- req=4'b1111 held, free high, ptr=0: grant order is 0, 1, 2, 3, 0, and each packet's bytes match its pkt_in.
- req=4'b0001, free_outbound=0 for 10 cycles, then 1:
  - grant pulses once.
  - put stays 0 and busy=1 until free is sampled.
  - Bytes follow 1 cycle later.
- During SEND cnt=1, drop free_outbound: all 4 bytes still emitted contiguously.
- During SEND cnt=2, assert rst for 1 cycle:
  - put/payload go 0 asynchronously; state IDLE, ptr=0.
  - After release with req=4'b0100, grant=4'b0100.
- With ROUTER_SCHED_WDOG_EN and TIMEOUT=255, hold free_outbound=0:
  - wdog_err rises after 255 WAIT_FREE cycles and stays 1 after free rises and the packet sends.
  - Without the macro, wdog_err stays 0.
